// File: rtl/rom_dl_sequencer.sv
// Routes HPS ROM download bytes into six one-hot ROM regions and sequences
// the game-core reset around each download window.
module rom_dl_sequencer #(
  parameter int unsigned HOLD_CYCLES = 256
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [16:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        ext_reset,
  output logic [5:0]  rom_we,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        dl_busy,
  output logic [16:0] dl_bytes,
  output logic [7:0]  dl_checksum,
  output logic        dl_overflow
);

  localparam int unsigned AW = 17;
  localparam int unsigned OW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 6;
  localparam int unsigned CW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  localparam logic [AW-1:0] BASE_SND  = 17'h0A000;
  localparam logic [AW-1:0] BASE_CHR  = 17'h0C000;
  localparam logic [AW-1:0] BASE_TIL  = 17'h0F000;
  localparam logic [AW-1:0] BASE_SPR  = 17'h15000;
  localparam logic [AW-1:0] BASE_MAP  = 17'h1B000;
  localparam logic [AW-1:0] MAP_END   = 17'h1C000;
  localparam logic [AW-1:0] BYTES_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic [NR-1:0]  r_rom_we;
  logic [OW-1:0]  r_rom_addr;
  logic [DW-1:0]  r_rom_data;
  logic           r_core_reset;
  logic           r_dl_busy;
  logic [AW-1:0]  r_dl_bytes;
  logic [DW-1:0]  r_dl_checksum;
  logic           r_dl_overflow;

  logic [NR-1:0]  w_sel;
  logic [AW-1:0]  w_base;
  logic           w_in_map;
  logic [OW-1:0]  w_offset;
  logic           w_accept;

  // Address map decode: region strobe and base of the region holding dn_addr.
  always_comb begin
    w_sel    = '0;
    w_base   = '0;
    w_in_map = 1'b1;
    if (dn_addr < BASE_SND) begin
      w_sel = 6'b000001;
    end else if (dn_addr < BASE_CHR) begin
      w_sel  = 6'b000010;
      w_base = BASE_SND;
    end else if (dn_addr < BASE_TIL) begin
      w_sel  = 6'b000100;
      w_base = BASE_CHR;
    end else if (dn_addr < BASE_SPR) begin
      w_sel  = 6'b001000;
      w_base = BASE_TIL;
    end else if (dn_addr < BASE_MAP) begin
      w_sel  = 6'b010000;
      w_base = BASE_SPR;
    end else if (dn_addr < MAP_END) begin
      w_sel  = 6'b100000;
      w_base = BASE_MAP;
    end else begin
      w_in_map = 1'b0;
    end
  end

  assign w_offset = OW'(dn_addr - w_base);
  // LOAD covers the falling cycle too: the state is still LOAD while dn_download is already low.
  assign w_accept = dn_wr && (r_state == ST_LOAD);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_HOLD;
      r_count       <= CW'(HOLD_CYCLES);
      r_rom_we      <= '0;
      r_rom_addr    <= '0;
      r_rom_data    <= '0;
      r_core_reset  <= 1'b1;
      r_dl_busy     <= 1'b0;
      r_dl_bytes    <= '0;
      r_dl_checksum <= '0;
      r_dl_overflow <= 1'b0;
    end else begin
      r_rom_we     <= '0;
      r_core_reset <= (r_state != ST_RUN) || ext_reset;

      case (r_state)
        ST_RUN: begin
          if (dn_download) begin
            r_state       <= ST_LOAD;
            r_dl_busy     <= 1'b1;
            r_dl_bytes    <= '0;
            r_dl_checksum <= '0;
            r_dl_overflow <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!dn_download) begin
            r_state   <= ST_HOLD;
            r_dl_busy <= 1'b0;
            r_count   <= CW'(HOLD_CYCLES);
          end
        end
        ST_HOLD: begin
          if (dn_download) begin
            r_state       <= ST_LOAD;
            r_dl_busy     <= 1'b1;
            r_dl_bytes    <= '0;
            r_dl_checksum <= '0;
            r_dl_overflow <= 1'b0;
          end else begin
            if (r_count <= CW'(1)) begin
              r_state <= ST_RUN;
            end
            if (r_count != '0) begin
              r_count <= r_count - CW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_HOLD;
          r_count <= CW'(HOLD_CYCLES);
        end
      endcase

      // Accepted bytes are disjoint from the entry clear above (accept only happens in LOAD).
      if (w_accept) begin
        if (r_dl_bytes != BYTES_MAX) begin
          r_dl_bytes <= r_dl_bytes + AW'(1);
        end
        r_dl_checksum <= r_dl_checksum + dn_data;
        if (w_in_map) begin
          r_rom_we   <= w_sel;
          r_rom_addr <= w_offset;
          r_rom_data <= dn_data;
        end else begin
          r_dl_overflow <= 1'b1;
        end
      end
    end
  end

  assign rom_we      = r_rom_we;
  assign rom_addr    = r_rom_addr;
  assign rom_data    = r_rom_data;
  assign core_reset  = r_core_reset;
  assign dl_busy     = r_dl_busy;
  assign dl_bytes    = r_dl_bytes;
  assign dl_checksum = r_dl_checksum;
  assign dl_overflow = r_dl_overflow;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Bench for rom_dl_sequencer: directed vector table, hand sequences for the
// reset/hold corner cases, then random traffic against a behavioural model.
module tb_rom_dl_sequencer;

  localparam int unsigned H = 20;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        dn_download = 1'b0;
  logic        dn_wr = 1'b0;
  logic [16:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic        ext_reset = 1'b0;
  logic [5:0]  rom_we;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset;
  logic        dl_busy;
  logic [16:0] dl_bytes;
  logic [7:0]  dl_checksum;
  logic        dl_overflow;

  always #5 clk_sys = ~clk_sys;

  rom_dl_sequencer #(.HOLD_CYCLES(H)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .dn_download(dn_download),
    .dn_wr      (dn_wr),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .ext_reset  (ext_reset),
    .rom_we     (rom_we),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .core_reset (core_reset),
    .dl_busy    (dl_busy),
    .dl_bytes   (dl_bytes),
    .dl_checksum(dl_checksum),
    .dl_overflow(dl_overflow)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: a download flag plus a count of reset cycles still owed.
  bit          m_loading;
  int          m_hold;
  int          m_bytes;
  int          m_sum;
  bit          m_ovf;
  logic [5:0]  m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  bit          m_core;
  bit          m_busy;
  int unsigned bases [6] = '{32'h00000, 32'h0A000, 32'h0C000, 32'h0F000, 32'h15000, 32'h1B000};

  typedef struct {
    bit          dl;
    bit          wr;
    logic [16:0] a;
    logic [7:0]  d;
    bit          ext;
    logic [5:0]  we;
    logic [15:0] ra;
    logic [7:0]  rd;
    bit          core;
    bit          busy;
    logic [16:0] bytes;
    logic [7:0]  sum;
    bit          ovf;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0;
    m_hold    = int'(H);
    m_bytes   = 0;
    m_sum     = 0;
    m_ovf     = 1'b0;
    m_we      = '0;
    m_addr    = '0;
    m_data    = '0;
    m_core    = 1'b1;
    m_busy    = 1'b0;
  endtask

  task automatic model_step(input bit dl, input bit wr, input logic [16:0] a,
                            input logic [7:0] d, input bit ext);
    int r;
    m_core = m_loading || (m_hold > 0) || ext;
    m_we   = '0;
    if (m_loading) begin
      if (wr) begin
        if (m_bytes < 32'h1FFFF) m_bytes++;
        m_sum = (m_sum + int'(d)) % 256;
        if (32'(a) >= 32'h1C000) begin
          m_ovf = 1'b1;
        end else begin
          r = 0;
          for (int i = 0; i < 6; i++) if (32'(a) >= bases[i]) r = i;
          m_we   = 6'(1 << r);
          m_addr = 16'(32'(a) - bases[r]);
          m_data = d;
        end
      end
      if (!dl) begin
        m_loading = 1'b0;
        m_hold    = int'(H);
      end
    end else if (dl) begin
      m_loading = 1'b1;
      m_hold    = 0;
      m_bytes   = 0;
      m_sum     = 0;
      m_ovf     = 1'b0;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    m_busy = m_loading;
  endtask

  task automatic cyc(input bit dl, input bit wr, input logic [16:0] a,
                     input logic [7:0] d, input bit ext);
    dn_download = dl;
    dn_wr       = wr;
    dn_addr     = a;
    dn_data     = d;
    ext_reset   = ext;
    model_step(dl, wr, a, d, ext);
    @(posedge clk_sys);
    #1;
    chk("model_we",    32'(rom_we),      32'(m_we));
    chk("model_addr",  32'(rom_addr),    32'(m_addr));
    chk("model_data",  32'(rom_data),    32'(m_data));
    chk("model_core",  32'(core_reset),  32'(m_core));
    chk("model_busy",  32'(dl_busy),     32'(m_busy));
    chk("model_bytes", 32'(dl_bytes),    32'(m_bytes));
    chk("model_sum",   32'(dl_checksum), 32'(m_sum));
    chk("model_ovf",   32'(dl_overflow), 32'(m_ovf));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_we"},    32'(rom_we),      32'h0);
    chk({tag, "_addr"},  32'(rom_addr),    32'h0);
    chk({tag, "_data"},  32'(rom_data),    32'h0);
    chk({tag, "_core"},  32'(core_reset),  32'h1);
    chk({tag, "_busy"},  32'(dl_busy),     32'h0);
    chk({tag, "_bytes"}, 32'(dl_bytes),    32'h0);
    chk({tag, "_sum"},   32'(dl_checksum), 32'h0);
    chk({tag, "_ovf"},   32'(dl_overflow), 32'h0);
  endtask

  initial begin
    bit dl_r;
    // dl wr addr data ext | we addr data core busy bytes sum ovf
    tbl[0] = '{1'b1, 1'b0, 17'h00000, 8'h00, 1'b0, 6'h00, 16'h0000, 8'h00, 1'b0, 1'b1, 17'd0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 17'h0A000, 8'h55, 1'b0, 6'h02, 16'h0000, 8'h55, 1'b1, 1'b1, 17'd1, 8'h55, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 17'h00000, 8'h00, 1'b0, 6'h00, 16'h0000, 8'h55, 1'b1, 1'b1, 17'd1, 8'h55, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 17'h00000, 8'h00, 1'b0, 6'h00, 16'h0000, 8'h55, 1'b1, 1'b0, 17'd1, 8'h55, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 17'h00000, 8'h00, 1'b0, 6'h00, 16'h0000, 8'h55, 1'b1, 1'b1, 17'd0, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 17'h1BFFF, 8'h01, 1'b0, 6'h20, 16'h0FFF, 8'h01, 1'b1, 1'b1, 17'd1, 8'h01, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 17'h1C000, 8'hFF, 1'b0, 6'h00, 16'h0FFF, 8'h01, 1'b1, 1'b1, 17'd2, 8'h00, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 17'h00000, 8'h10, 1'b0, 6'h01, 16'h0000, 8'h10, 1'b1, 1'b1, 17'd3, 8'h10, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 17'h00000, 8'h00, 1'b0, 6'h00, 16'h0000, 8'h10, 1'b1, 1'b0, 17'd3, 8'h10, 1'b1};

    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    chk_reset_values("por");
    reset_n = 1'b1;

    // Idle after reset: core held for H cycles, no ROM writes.
    for (int k = 1; k <= int'(H) + 2; k++) begin
      cyc(1'b0, 1'b0, 17'h0, 8'h0, 1'b0);
      chk("idle_core", 32'(core_reset), 32'(k <= int'(H)));
      chk("idle_we",   32'(rom_we),     32'h0);
    end

    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].dl, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].ext);
      chk($sformatf("vec%0d_we", i),    32'(rom_we),      32'(tbl[i].we));
      chk($sformatf("vec%0d_addr", i),  32'(rom_addr),    32'(tbl[i].ra));
      chk($sformatf("vec%0d_data", i),  32'(rom_data),    32'(tbl[i].rd));
      chk($sformatf("vec%0d_core", i),  32'(core_reset),  32'(tbl[i].core));
      chk($sformatf("vec%0d_busy", i),  32'(dl_busy),     32'(tbl[i].busy));
      chk($sformatf("vec%0d_bytes", i), 32'(dl_bytes),    32'(tbl[i].bytes));
      chk($sformatf("vec%0d_sum", i),   32'(dl_checksum), 32'(tbl[i].sum));
      chk($sformatf("vec%0d_ovf", i),   32'(dl_overflow), 32'(tbl[i].ovf));
    end

    // Re-enter LOAD with the hold counter at 10.
    for (int j = 1; j <= 10; j++) begin
      cyc(1'b0, 1'b0, 17'h0, 8'h0, 1'b0);
      chk("rehold_core", 32'(core_reset), 32'h1);
    end
    cyc(1'b1, 1'b0, 17'h0, 8'h0, 1'b0);
    chk("reload_busy",  32'(dl_busy),     32'h1);
    chk("reload_bytes", 32'(dl_bytes),    32'h0);
    chk("reload_sum",   32'(dl_checksum), 32'h0);
    chk("reload_ovf",   32'(dl_overflow), 32'h0);
    chk("reload_core",  32'(core_reset),  32'h1);
    repeat (2) begin
      cyc(1'b1, 1'b0, 17'h0, 8'h0, 1'b0);
      chk("reload_core2", 32'(core_reset), 32'h1);
    end

    // Byte on the cycle dn_download falls.
    cyc(1'b1, 1'b1, 17'h0B123, 8'h3C, 1'b0);
    chk("snd_we",   32'(rom_we),   32'h02);
    chk("snd_addr", 32'(rom_addr), 32'h1123);
    cyc(1'b0, 1'b1, 17'h0C005, 8'hA5, 1'b0);
    chk("fall_we",    32'(rom_we),      32'h04);
    chk("fall_addr",  32'(rom_addr),    32'h0005);
    chk("fall_data",  32'(rom_data),    32'hA5);
    chk("fall_busy",  32'(dl_busy),     32'h0);
    chk("fall_bytes", 32'(dl_bytes),    32'd2);
    chk("fall_sum",   32'(dl_checksum), 32'hE1);
    for (int k = 1; k <= int'(H) + 1; k++) begin
      cyc(1'b0, 1'b0, 17'h0, 8'h0, 1'b0);
      chk("fall_hold_core", 32'(core_reset), 32'(k <= int'(H)));
      chk("fall_hold_we",   32'(rom_we),     32'h0);
    end

    // ext_reset pulse in RUN.
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 1'b0, 17'h0, 8'h0, 1'b1);
      chk("ext_core", 32'(core_reset), 32'h1);
    end
    cyc(1'b0, 1'b0, 17'h0, 8'h0, 1'b0);
    chk("ext_core_off", 32'(core_reset), 32'h0);
    chk("ext_busy",     32'(dl_busy),    32'h0);

    // Writes outside LOAD are ignored, including the rising cycle.
    cyc(1'b0, 1'b1, 17'h00010, 8'h77, 1'b0);
    chk("run_wr_we",    32'(rom_we),   32'h0);
    chk("run_wr_bytes", 32'(dl_bytes), 32'd2);
    cyc(1'b1, 1'b1, 17'h00020, 8'h66, 1'b0);
    chk("rise_wr_we",    32'(rom_we),   32'h0);
    chk("rise_wr_bytes", 32'(dl_bytes), 32'd0);
    chk("rise_wr_busy",  32'(dl_busy),  32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 17'(32'h15000 + i), 8'(8'hC0 + i), 1'b0);
      chk("b2b_we",    32'(rom_we),   32'h10);
      chk("b2b_addr",  32'(rom_addr), 32'(i));
      chk("b2b_data",  32'(rom_data), 32'(8'hC0 + i));
      chk("b2b_bytes", 32'(dl_bytes), 32'(i + 1));
    end

    // Asynchronous reset in the middle of a download.
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_values("mid");
    model_reset();
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    cyc(1'b1, 1'b0, 17'h0, 8'h0, 1'b0);
    chk("mid_busy",  32'(dl_busy),    32'h1);
    chk("mid_bytes", 32'(dl_bytes),   32'h0);
    chk("mid_core",  32'(core_reset), 32'h1);
    cyc(1'b1, 1'b1, 17'h1B010, 8'h42, 1'b0);
    chk("mid_we",    32'(rom_we),      32'h20);
    chk("mid_addr",  32'(rom_addr),    32'h0010);
    chk("mid_sum",   32'(dl_checksum), 32'h42);
    chk("mid_bytes2", 32'(dl_bytes),   32'd1);

    // Random traffic against the model.
    dl_r = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 4) dl_r = !dl_r;
      cyc(dl_r, 1'($urandom_range(0, 1)), 17'($urandom_range(0, 32'h1D000)),
          8'($urandom_range(0, 255)), $urandom_range(0, 99) < 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_dl_sequencer.md
ROM_DL_SEQUENCER -- requirements
Module: rom_dl_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 256: number of clk_sys cycles core_reset stays asserted after a download ends.
REQ-002 SHALL have port clk_sys, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port dn_download, input, 1: HPS download window active.
REQ-005 SHALL have port dn_wr, input, 1: one-cycle byte strobe.
REQ-006 SHALL have port dn_addr, input, 17: download byte address.
REQ-007 SHALL have port dn_data, input, 8: download byte.
REQ-008 SHALL have port ext_reset, input, 1: OR of user/menu reset requests.
REQ-009 SHALL have port rom_we, output, 6: one-hot region write strobe.
REQ-010 SHALL have port rom_addr, output, 16: offset within the selected region.
REQ-011 SHALL have port rom_data, output, 8: byte to write.
REQ-012 SHALL have port core_reset, output, 1: active-high reset to the game core.
REQ-013 SHALL have port dl_busy, output, 1: high in LOAD state.
REQ-014 SHALL have port dl_bytes, output, 17: count of bytes accepted in the current/last download.
REQ-015 SHALL have port dl_checksum, output, 8: mod-256 sum of accepted bytes.
REQ-016 SHALL have port dl_overflow, output, 1: sticky flag, byte addressed beyond the map.

Function
REQ-017 SHALL decode dn_addr to regions: 0 CPU 0x00000-0x09FFF; 1 sound 0x0A000-0x0BFFF; 2 char 0x0C000-0x0EFFF; 3 tile 0x0F000-0x14FFF; 4 sprite 0x15000-0x1AFFF; 5 map 0x1B000-0x1BFFF.
REQ-018 SHALL output rom_addr = dn_addr minus region base, zero-extended to 16 bits.
REQ-019 SHALL use FSM states RUN, LOAD, HOLD; reset state HOLD with counter = HOLD_CYCLES.
REQ-020 SHALL move RUN->LOAD or HOLD->LOAD on dn_download=1, clearing dl_bytes, dl_checksum and dl_overflow on entry.
REQ-021 SHALL move LOAD->HOLD when dn_download falls, loading counter = HOLD_CYCLES.
REQ-022 In HOLD, the counter SHALL decrement each cycle, and the FSM SHALL move HOLD->RUN the cycle it reaches 0.
REQ-023 SHALL accept dn_wr only in LOAD or on the exact cycle dn_download falls; dn_wr at any other time SHALL be ignored.
REQ-024 Each accepted in-map byte SHALL produce exactly one rom_we pulse one cycle later (registered), carrying registered rom_addr and rom_data.
REQ-025 rom_we SHALL be all-zero in every other cycle.
REQ-026 An accepted out-of-map byte (>=0x1C000) SHALL set dl_overflow, produce no rom_we, and still count toward dl_bytes and dl_checksum.
REQ-027 dl_bytes SHALL saturate at 0x1FFFF.
REQ-028 dl_checksum SHALL wrap modulo 256.
REQ-029 core_reset SHALL be asserted, registered, whenever the state is LOAD or HOLD, or ext_reset=1.
REQ-030 ext_reset in RUN SHALL assert core_reset combined-registered (one cycle later) without changing state.
REQ-031 Back-to-back dn_wr on consecutive cycles SHALL each be written without loss.

Reset
REQ-032 While reset_n=0, the block SHALL hold rom_we=0, rom_addr=0, rom_data=0, core_reset=1, dl_busy=0, dl_bytes=0, dl_checksum=0, dl_overflow=0, state HOLD, counter=HOLD_CYCLES.
REQ-033 Reset_n deasserting mid-download SHALL re-enter LOAD on the next cycle if dn_download=1; bytes written before reset are not recounted.

Verification
REQ-034 The bench SHALL cover: reset release with dn_download=0 -> core_reset=1 for HOLD_CYCLES cycles, then 0; rom_we never pulses.
REQ-035 The bench SHALL cover: download of 0x0A000=0x55 -> rom_we=6'b000010, rom_addr=0x0000, rom_data=0x55 exactly one cycle after dn_wr.
REQ-036 The bench SHALL cover: bytes 0x01,0xFF,0x10 at 0x1BFFF,0x1C000,0x00000 -> two writes (region 5 offset 0x0FFF; region 0 offset 0); dl_overflow=1; dl_bytes=3; dl_checksum=0x10.
REQ-037 The bench SHALL cover: dn_wr on the cycle dn_download falls -> byte written, state HOLD, core_reset held HOLD_CYCLES more cycles.
REQ-038 The bench SHALL cover: dn_download re-asserted at HOLD counter=10 -> back to LOAD, counters cleared, core_reset stays 1 continuously.
REQ-039 The bench SHALL cover: ext_reset pulsed 3 cycles in RUN -> core_reset high 3 cycles, delayed by 1; state remains RUN.
